// File: rtl/vga_sprite_gen_pkg.sv
// Shared definitions for the bouncing-sprite generator: {R,G,B} colours and FSM states.
package vga_sprite_gen_pkg;

    typedef logic [2:0] colour_t;

    localparam colour_t BLACK = 3'b000;
    localparam colour_t BLUE  = 3'b001;
    localparam colour_t RED   = 3'b100;
    localparam colour_t WHITE = 3'b111;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        MOVE_X     = 2'd1,
        MOVE_Y     = 2'd2
    } state_t;

endpackage

// File: rtl/sprite_axis.sv
// One axis of sprite motion: position/direction register with edge bounce.
module sprite_axis #(
    parameter int unsigned ACTIVE      = 640,
    parameter int unsigned SPRITE_SIZE = 32,
    parameter int unsigned STEP        = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_step,
    output logic [9:0] o_pos,
    output logic       o_dir,
    output logic       o_bounce
);

    logic [9:0]  r_pos;
    logic        r_dir;
    logic [10:0] w_fwd_end;
    logic        w_can_fwd;
    logic        w_can_back;

    // 11-bit sum so pos + step + size never wraps
    assign w_fwd_end  = {1'b0, r_pos} + 11'(STEP) + 11'(SPRITE_SIZE);
    assign w_can_fwd  = (w_fwd_end <= 11'(ACTIVE));
    assign w_can_back = ({1'b0, r_pos} >= 11'(STEP));

    assign o_bounce = i_step && (r_dir ? !w_can_fwd : !w_can_back);
    assign o_pos    = r_pos;
    assign o_dir    = r_dir;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pos <= '0;
            r_dir <= 1'b1;
        end else if (i_step) begin
            if (r_dir) begin
                if (w_can_fwd) begin
                    r_pos <= r_pos + 10'(STEP);
                end else begin
                    r_pos <= 10'(ACTIVE - SPRITE_SIZE);
                    r_dir <= 1'b0;
                end
            end else begin
                if (w_can_back) begin
                    r_pos <= r_pos - 10'(STEP);
                end else begin
                    r_pos <= '0;
                    r_dir <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vga_sprite_gen.sv
// Bouncing square sprite for a VGA controller; moves once per frame (X then Y).
// Define SPRITE_BORDER_EN to draw a 1-pixel WHITE ring around the RED sprite.
module vga_sprite_gen
    import vga_sprite_gen_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned SPRITE_SIZE = 32,
    parameter int unsigned STEP        = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Enable,
    input  logic [9:0] iColumn,
    input  logic [9:0] iRow,
    input  logic       iFrameStart,
    output logic [2:0] oPixel,
    output logic [7:0] oBounceCount
);

    state_t      r_state;
    state_t      w_state_next;
    colour_t     r_pixel;
    colour_t     w_sprite_colour;
    logic [7:0]  r_bounce_count;
    logic [9:0]  w_x;
    logic [9:0]  w_y;
    logic        w_dx;
    logic        w_dy;
    logic        w_bounce_x;
    logic        w_bounce_y;
    logic [10:0] w_col;
    logic [10:0] w_row;
    logic [10:0] w_x_end;
    logic [10:0] w_y_end;
    logic        w_in_sprite;
    logic        w_visible;

    sprite_axis #(
        .ACTIVE      (H_ACTIVE),
        .SPRITE_SIZE (SPRITE_SIZE),
        .STEP        (STEP)
    ) u_axis_x (
        .i_clk    (Clock),
        .i_rst    (Reset),
        .i_step   (Enable && (r_state == MOVE_X)),
        .o_pos    (w_x),
        .o_dir    (w_dx),
        .o_bounce (w_bounce_x)
    );

    sprite_axis #(
        .ACTIVE      (V_ACTIVE),
        .SPRITE_SIZE (SPRITE_SIZE),
        .STEP        (STEP)
    ) u_axis_y (
        .i_clk    (Clock),
        .i_rst    (Reset),
        .i_step   (Enable && (r_state == MOVE_Y)),
        .o_pos    (w_y),
        .o_dir    (w_dy),
        .o_bounce (w_bounce_y)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            WAIT_FRAME: if (iFrameStart) w_state_next = MOVE_X;
            MOVE_X:     w_state_next = MOVE_Y;
            MOVE_Y:     w_state_next = WAIT_FRAME;
            default:    w_state_next = WAIT_FRAME;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= WAIT_FRAME;
        end else if (Enable) begin
            r_state <= w_state_next;
        end
    end

    // The two axes move in different cycles, so at most one bounce per edge
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_bounce_count <= '0;
        end else if (w_bounce_x || w_bounce_y) begin
            r_bounce_count <= r_bounce_count + 8'd1;
        end
    end

    assign w_col       = {1'b0, iColumn};
    assign w_row       = {1'b0, iRow};
    assign w_x_end     = {1'b0, w_x} + 11'(SPRITE_SIZE);
    assign w_y_end     = {1'b0, w_y} + 11'(SPRITE_SIZE);
    assign w_visible   = (w_col < 11'(H_ACTIVE)) && (w_row < 11'(V_ACTIVE));
    assign w_in_sprite = (iColumn >= w_x) && (w_col < w_x_end) &&
                         (iRow >= w_y) && (w_row < w_y_end);

`ifdef SPRITE_BORDER_EN
    always_comb begin
        w_sprite_colour = RED;
        if ((iColumn == w_x) || (w_col == w_x_end - 11'd1) ||
            (iRow == w_y) || (w_row == w_y_end - 11'd1)) begin
            w_sprite_colour = WHITE;
        end
    end
`else
    assign w_sprite_colour = RED;
`endif

    always_ff @(posedge Clock) begin
        if (Reset || !Enable || !w_visible) begin
            r_pixel <= BLACK;
        end else if (w_in_sprite) begin
            r_pixel <= w_sprite_colour;
        end else begin
            r_pixel <= BLUE;
        end
    end

    assign oPixel       = r_pixel;
    assign oBounceCount = r_bounce_count;

endmodule

// File: tb/tb_vga_sprite_gen.sv
// Scoreboard bench: a default-size DUT and a small 64x64 DUT share stimulus; a model predicts both.
module tb_vga_sprite_gen;
    import vga_sprite_gen_pkg::*;

    localparam int HA = 640, VA = 480, SA = 32, STA = 2;
    localparam int HB = 64,  VB = 64,  SB = 32, STB = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       fs;
    logic [9:0] col;
    logic [9:0] row;
    logic [2:0] pix_a, pix_b;
    logic [7:0] cnt_a, cnt_b;

    int checks = 0;
    int errors = 0;

    int mh[2] = '{HA, HB};
    int mv[2] = '{VA, VB};
    int ms[2] = '{SA, SB};
    int mst[2] = '{STA, STB};
    int mx[2], my[2], mdx[2], mdy[2], mc[2];

    int q_pix_a[$], q_pix_b[$], q_cnt_a[$], q_cnt_b[$];

    always #5 clk = ~clk;

    vga_sprite_gen u_dut_a (
        .Clock        (clk),
        .Reset        (rst),
        .Enable       (en),
        .iColumn      (col),
        .iRow         (row),
        .iFrameStart  (fs),
        .oPixel       (pix_a),
        .oBounceCount (cnt_a)
    );

    vga_sprite_gen #(
        .H_ACTIVE    (HB),
        .V_ACTIVE    (VB),
        .SPRITE_SIZE (SB),
        .STEP        (STB)
    ) u_dut_b (
        .Clock        (clk),
        .Reset        (rst),
        .Enable       (en),
        .iColumn      (col),
        .iRow         (row),
        .iFrameStart  (fs),
        .oPixel       (pix_b),
        .oBounceCount (cnt_b)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mx[d] = 0; my[d] = 0; mdx[d] = 1; mdy[d] = 1; mc[d] = 0;
        end
    endtask

    task automatic axis_step(input int pos, input int dir, input int act, input int size,
                             input int step, output int npos, output int ndir,
                             output int bump);
        npos = pos; ndir = dir; bump = 0;
        if (dir == 1) begin
            if (pos + step + size <= act) npos = pos + step;
            else begin npos = act - size; ndir = 0; bump = 1; end
        end else begin
            if (pos >= step) npos = pos - step;
            else begin npos = 0; ndir = 1; bump = 1; end
        end
    endtask

    task automatic model_frame();
        int np, nd, b;
        for (int d = 0; d < 2; d++) begin
            axis_step(mx[d], mdx[d], mh[d], ms[d], mst[d], np, nd, b);
            mx[d] = np; mdx[d] = nd; mc[d] = (mc[d] + b) % 256;
            axis_step(my[d], mdy[d], mv[d], ms[d], mst[d], np, nd, b);
            my[d] = np; mdy[d] = nd; mc[d] = (mc[d] + b) % 256;
        end
    endtask

    function automatic int pix_model(input int d, input int c, input int r, input bit e);
        if (!e) return int'(BLACK);
        if (c >= mh[d] || r >= mv[d]) return int'(BLACK);
        if (c >= mx[d] && c < mx[d] + ms[d] && r >= my[d] && r < my[d] + ms[d]) begin
`ifdef SPRITE_BORDER_EN
            if (c == mx[d] || c == mx[d] + ms[d] - 1 || r == my[d] || r == my[d] + ms[d] - 1)
                return int'(WHITE);
`endif
            return int'(RED);
        end
        return int'(BLUE);
    endfunction

    task automatic probe(input int c, input int r);
        col = 10'(c);
        row = 10'(r);
        q_pix_a.push_back(pix_model(0, c, r, en));
        q_pix_b.push_back(pix_model(1, c, r, en));
        @(posedge clk); #1;
        check_eq($sformatf("pix_a(%0d,%0d)", c, r), int'(pix_a), q_pix_a.pop_front());
        check_eq($sformatf("pix_b(%0d,%0d)", c, r), int'(pix_b), q_pix_b.pop_front());
    endtask

    task automatic check_counts(input string tag);
        check_eq({tag, "_cnt_a"}, int'(cnt_a), q_cnt_a.pop_front());
        check_eq({tag, "_cnt_b"}, int'(cnt_b), q_cnt_b.pop_front());
    endtask

    // One frame pulse; dbl re-asserts iFrameStart while the DUT sits in MOVE_X
    task automatic frame(input bit dbl);
        fs = 1'b1;
        if (en) model_frame();
        q_cnt_a.push_back(mc[0]);
        q_cnt_b.push_back(mc[1]);
        @(posedge clk); #1;
        fs = dbl;
        @(posedge clk); #1;
        fs = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_counts("frame");
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; fs = 1'b1; col = 10'd5; row = 10'd5;
        model_reset();
        q_pix_a.push_back(int'(BLACK));
        q_pix_b.push_back(int'(BLACK));
        q_cnt_a.push_back(0);
        q_cnt_b.push_back(0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_pix_a", int'(pix_a), q_pix_a.pop_front());
        check_eq("rst_pix_b", int'(pix_b), q_pix_b.pop_front());
        check_counts("rst");
        rst = 1'b0; fs = 1'b0;

        // Latency and colour map around the reset position
        probe(5, 5);   probe(40, 5);   probe(700, 5);  probe(5, 500);
        probe(31, 31); probe(32, 31);  probe(31, 32);  probe(0, 10);
        probe(1, 10);  probe(639, 0);  probe(640, 0);  probe(0, 479);
        probe(0, 480); probe(63, 0);   probe(64, 0);

        frame(1'b0);
        probe(1, 5); probe(2, 2); probe(33, 33); probe(34, 2);

        // Freeze: pulses while disabled are dropped, pixel goes BLACK
        en = 1'b0;
        repeat (3) frame(1'b0);
        probe(2, 2);
        en = 1'b1;
        probe(2, 2); probe(1, 2);

        // Second pulse during MOVE_X must give a single step
        frame(1'b1);
        probe(mx[0], my[0]); probe(mx[0] - 1, my[0]); probe(mx[1] + SB, my[1]);

        for (int i = 0; i < 320; i++) begin
            frame(i % 7 == 3);
            probe(mx[0], my[0]);
            probe(mx[0] + SA, my[0] + SA - 1);
            probe(mx[1], my[1]);
            probe(mx[1] + SB - 1, my[1] + SB - 1);
            if (mx[1] > 0) probe(mx[1] - 1, my[1]);
        end

        // Reset arriving mid-MOVE_X wins over the pending move
        fs = 1'b1;
        @(posedge clk); #1;
        fs = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        q_cnt_a.push_back(0);
        q_cnt_b.push_back(0);
        check_counts("midrst");
        probe(0, 0); probe(31, 31); probe(32, 0);
        frame(1'b0);
        probe(2, 2); probe(1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_sprite_gen.md
VGA_SPRITE_GEN -- requirements
Module: vga_sprite_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible columns.
REQ-002 SHALL have parameter V_ACTIVE, default 480, visible rows.
REQ-003 SHALL have parameter SPRITE_SIZE, default 32, sprite edge length in pixels.
REQ-004 SHALL have parameter STEP, default 2, pixels moved per axis per frame.
REQ-005 SHALL have port Clock  input  1  pixel clock; one clock; all logic on posedge.
REQ-006 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port Enable  input  1  high = run; low = freeze all state.
REQ-008 SHALL have port iColumn  input  10  current pixel column from the VGA controller.
REQ-009 SHALL have port iRow  input  10  current pixel row from the VGA controller.
REQ-010 SHALL have port iFrameStart  input  1  one-cycle pulse at the start of vertical blanking.
REQ-011 SHALL have port oPixel  output  3  {R,G,B} colour that drives the VGA controller's iPixel.
REQ-012 SHALL have port oBounceCount  output  8  count of edge bounces.

Function
REQ-013 SHALL hold sprite position X,Y (10 bits each) and direction bits DX,DY (1 = increasing).
REQ-014 SHALL implement FSM states WAIT_FRAME, MOVE_X, MOVE_Y.
- WAIT_FRAME->MOVE_X on iFrameStart.
- MOVE_X->MOVE_Y unconditionally.
- MOVE_Y->WAIT_FRAME unconditionally.
REQ-015 SHALL ignore iFrameStart while in MOVE_X or MOVE_Y; no queuing.
REQ-016 SHALL, in MOVE_X with DX=1, set X=X+STEP when X+STEP+SPRITE_SIZE<=H_ACTIVE; otherwise set X=H_ACTIVE-SPRITE_SIZE, clear DX and increment oBounceCount.
REQ-017 SHALL, in MOVE_X with DX=0, set X=X-STEP when X>=STEP; otherwise set X=0, set DX and increment oBounceCount.
REQ-018 SHALL apply REQ-016/017 in MOVE_Y, substituting Y, DY and V_ACTIVE.
REQ-019 SHALL compute boundary sums at 11-bit width so no intermediate overflow occurs.
REQ-020 SHALL let oBounceCount wrap from 255 to 0; a corner hit increments it twice, once in MOVE_X and once in MOVE_Y.
REQ-021 SHALL register oPixel with exactly 1 cycle latency from iColumn/iRow.
REQ-022 SHALL drive oPixel RED when X<=iColumn<X+SPRITE_SIZE and Y<=iRow<Y+SPRITE_SIZE; otherwise BLUE.
REQ-023 SHALL drive oPixel BLACK whenever iColumn>=H_ACTIVE or iRow>=V_ACTIVE.
REQ-024 SHALL, with Enable low, hold FSM, X, Y, DX, DY and oBounceCount, drive oPixel BLACK, and drop any iFrameStart pulse.

Reset
REQ-025 SHALL, on Reset, set FSM=WAIT_FRAME, X=0, Y=0, DX=1, DY=1, oBounceCount=0 and oPixel=BLACK on the next edge.
REQ-026 SHALL let Reset override Enable and iFrameStart, including a Reset asserted mid-MOVE_X or mid-MOVE_Y.

Configuration
REQ-027 SHALL, with macro SPRITE_BORDER_EN defined, draw the sprite's outermost 1-pixel ring WHITE and its interior RED.
REQ-028 SHALL, with SPRITE_BORDER_EN undefined, fill the whole sprite RED and synthesize no border-compare logic.

Structure
REQ-029 SHALL take colour constants BLACK, BLUE, RED and WHITE from the shared definitions header; no local colour literals.
REQ-030 SHALL implement per-axis step/bounce logic as one sub-module, sprite_axis, instantiated twice: once for X with H_ACTIVE, once for Y with V_ACTIVE.

Verification
REQ-031 SHALL cover reset: assert Reset 2 cycles -> X=0, Y=0, DX=DY=1, oBounceCount=0, oPixel=BLACK.
REQ-032 SHALL cover pixel latency: X=Y=0, present col=5,row=5 -> oPixel=RED one cycle later; present col=40 -> BLUE; present col=700 -> BLACK.
REQ-033 SHALL cover right-edge bounce: X=607, DX=1, one iFrameStart -> X=608, DX=0, oBounceCount=1.
REQ-034 SHALL cover corner bounce: X=0, Y=0, DX=DY=0, one iFrameStart -> X=0, Y=0, DX=DY=1, oBounceCount +2.
REQ-035 SHALL cover freeze and pulse handling: Enable=0 across 3 iFrameStart pulses -> no state change; a second iFrameStart during MOVE_X -> a single step only.
REQ-036 SHALL cover the border option: with SPRITE_BORDER_EN and X=Y=0, col=0,row=10 -> WHITE; col=1,row=10 -> RED.
